operand_stack: RTL and testbench

- Hardware operand stack for the stack CPU datapath. Sits between the decode/control stage and the ALU.
- The control stage issues push/pop commands. The block presents top-of-stack (TOS) and next-on-stack (NOS) to the ALU as operands, and accepts the ALU result back as a push or replace.
- Replaces memory-backed stack traffic for arithmetic, so `memory_data` carries only load/store data.

---
 rtl/operand_stack_if.sv | 27 ++
 rtl/operand_stack.sv | 119 +++++++++++
 tb/tb_operand_stack.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// Operand-stack bus between the control stage (master) and the stack (slave).
interface operand_stack_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic                       push;
  logic                       pop;
  logic                       clr_err;
  logic [DATA_WIDTH-1:0]      din;
  logic [DATA_WIDTH-1:0]      tos;
  logic [DATA_WIDTH-1:0]      nos;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output push, pop, clr_err, din,
    input  tos, nos, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err, din,
    output tos, nos, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// Hardware operand stack: registered TOS plus an array for deeper entries.
// Define STACK_BOUNDS_CHECK_EN to drop illegal push/pop and enable sticky error flags.
module operand_stack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input logic                clk,
  input logic                rst,
  operand_stack_if.slave     bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       sp, nos_idx;
  logic [DATA_WIDTH-1:0] nos;
  logic                  mem_we;
  logic                  is_empty, is_full;

  // sp = count - 1; only meaningful when count >= 1
  assign sp       = count_q[PtrW-1:0] - PtrW'(1);
  assign nos_idx  = sp - PtrW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CntW'(DEPTH));
  assign nos      = (count_q >= CntW'(2)) ? mem_q[nos_idx] : '0;

`ifdef STACK_BOUNDS_CHECK_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
`endif

  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    mem_we  = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
    ovf_d = ovf_q;
    udf_d = udf_q;
    // A fresh error set below overrides a same-cycle clear
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
`endif
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
`ifdef STACK_BOUNDS_CHECK_EN
          ovf_d = 1'b1;
`else
          mem_we = 1'b1;
          tos_d  = bus.din;
`endif
        end else begin
          mem_we  = !is_empty;
          tos_d   = bus.din;
          count_d = count_q + CntW'(1);
        end
      end
      2'b01: begin
        if (is_empty) begin
`ifdef STACK_BOUNDS_CHECK_EN
          udf_d = 1'b1;
`endif
        end else begin
          tos_d   = nos;
          count_d = count_q - CntW'(1);
        end
      end
      2'b11: begin
        tos_d = bus.din;
        if (is_empty) count_d = CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Array contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[sp] <= tos_q;
  end

`ifdef STACK_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.tos   = tos_q;
  assign bus.nos   = nos;
  assign bus.count = count_q;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack (DATA_WIDTH=8, DEPTH=4).
// Error-flag expectations follow whether STACK_BOUNDS_CHECK_EN is defined.
module tb_operand_stack;
`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  operand_stack_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

  operand_stack #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cmd(input logic p, input logic q, input logic [7:0] d, input logic c);
    @(negedge clk);
    bus.push = p; bus.pop = q; bus.din = d; bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00; bus.clr_err = 1'b0;
  endtask

  task automatic test_reset;
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00; bus.clr_err = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.tos !== 8'h00) begin failures++; $display("FAIL reset_tos got=%h exp=00", bus.tos); end
    checks++; if (bus.nos !== 8'h00) begin failures++; $display("FAIL reset_nos got=%h exp=00", bus.nos); end
    checks++; if ({bus.empty, bus.full, bus.overflow, bus.underflow} !== 4'b1000) begin
      failures++; $display("FAIL reset_flags got=%b exp=1000",
                           {bus.empty, bus.full, bus.overflow, bus.underflow});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_push;
    cmd(1'b1, 1'b0, 8'h11, 1'b0);
    checks++; if (bus.tos !== 8'h11 || bus.nos !== 8'h00) begin
      failures++; $display("FAIL push1 tos=%h nos=%h exp=11/00", bus.tos, bus.nos);
    end
    cmd(1'b1, 1'b0, 8'h22, 1'b0);
    cmd(1'b1, 1'b0, 8'h33, 1'b0);
    checks++; if (bus.tos !== 8'h33) begin failures++; $display("FAIL push_tos got=%h exp=33", bus.tos); end
    checks++; if (bus.nos !== 8'h22) begin failures++; $display("FAIL push_nos got=%h exp=22", bus.nos); end
    checks++; if (bus.count !== 3'd3 || bus.empty !== 1'b0 || bus.full !== 1'b0) begin
      failures++; $display("FAIL push_count count=%0d empty=%b full=%b exp=3/0/0",
                           bus.count, bus.empty, bus.full);
    end
  endtask

  task automatic test_overflow;
    cmd(1'b1, 1'b0, 8'h44, 1'b0);
    checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.tos !== 8'h44) begin
      failures++; $display("FAIL fill full=%b count=%0d tos=%h exp=1/4/44", bus.full, bus.count, bus.tos);
    end
    cmd(1'b1, 1'b0, 8'h55, 1'b0);
    checks++; if (bus.overflow !== Chk) begin
      failures++; $display("FAIL overflow_set got=%b exp=%b", bus.overflow, Chk);
    end
    checks++; if (bus.tos !== (Chk ? 8'h44 : 8'h55) || bus.count !== 3'd4 || bus.full !== 1'b1) begin
      failures++; $display("FAIL overflow_state tos=%h count=%0d full=%b", bus.tos, bus.count, bus.full);
    end
    checks++; if (bus.nos !== 8'h33) begin failures++; $display("FAIL overflow_nos got=%h exp=33", bus.nos); end
    cmd(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%b exp=0", bus.overflow); end
    // Drain: each pop promotes NOS
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.tos !== 8'h33 || bus.count !== 3'd3 || bus.full !== 1'b0) begin
      failures++; $display("FAIL pop1 tos=%h count=%0d full=%b exp=33/3/0", bus.tos, bus.count, bus.full);
    end
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.tos !== 8'h11 || bus.count !== 3'd1 || bus.nos !== 8'h00) begin
      failures++; $display("FAIL pop3 tos=%h count=%0d nos=%h exp=11/1/00", bus.tos, bus.count, bus.nos);
    end
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.tos !== 8'h00 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL pop_last tos=%h count=%0d empty=%b exp=00/0/1", bus.tos, bus.count, bus.empty);
    end
  endtask

  task automatic test_binary_op;
    cmd(1'b1, 1'b0, 8'h11, 1'b0);
    cmd(1'b1, 1'b0, 8'h22, 1'b0);
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.tos !== 8'h11 || bus.count !== 3'd1) begin
      failures++; $display("FAIL binop_pop tos=%h count=%0d exp=11/1", bus.tos, bus.count);
    end
    cmd(1'b1, 1'b1, 8'h33, 1'b0);
    checks++; if (bus.tos !== 8'h33 || bus.count !== 3'd1 || bus.nos !== 8'h00) begin
      failures++; $display("FAIL binop_replace tos=%h count=%0d nos=%h exp=33/1/00", bus.tos, bus.count, bus.nos);
    end
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_underflow;
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.underflow !== Chk || bus.count !== 3'd0 || bus.tos !== 8'h00) begin
      failures++; $display("FAIL underflow_set udf=%b count=%0d tos=%h exp=%b/0/00",
                           bus.underflow, bus.count, bus.tos, Chk);
    end
    cmd(1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if (bus.underflow !== Chk) begin
      failures++; $display("FAIL underflow_beats_clr got=%b exp=%b", bus.underflow, Chk);
    end
    cmd(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL clr_underflow got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_replace;
    cmd(1'b1, 1'b1, 8'h7f, 1'b0);
    checks++; if (bus.count !== 3'd1 || bus.tos !== 8'h7f) begin
      failures++; $display("FAIL replace_empty count=%0d tos=%h exp=1/7f", bus.count, bus.tos);
    end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      failures++; $display("FAIL replace_empty_err ovf=%b udf=%b exp=0/0", bus.overflow, bus.underflow);
    end
    cmd(1'b1, 1'b0, 8'h02, 1'b0);
    cmd(1'b1, 1'b0, 8'h03, 1'b0);
    cmd(1'b1, 1'b0, 8'h04, 1'b0);
    cmd(1'b1, 1'b1, 8'h01, 1'b0);
    checks++; if (bus.count !== 3'd4 || bus.tos !== 8'h01 || bus.full !== 1'b1) begin
      failures++; $display("FAIL replace_full count=%0d tos=%h full=%b exp=4/01/1", bus.count, bus.tos, bus.full);
    end
    checks++; if (bus.nos !== 8'h03 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL replace_full_nos nos=%h ovf=%b exp=03/0", bus.nos, bus.overflow);
    end
  endtask

  task automatic test_async_reset;
    cmd(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL pre_reset_count got=%0d exp=3", bus.count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.tos !== 8'h00 || bus.nos !== 8'h00) begin
      failures++; $display("FAIL async_reset count=%0d tos=%h nos=%h exp=0/00/00", bus.count, bus.tos, bus.nos);
    end
    checks++; if ({bus.empty, bus.full, bus.overflow, bus.underflow} !== 4'b1000) begin
      failures++; $display("FAIL async_reset_flags got=%b exp=1000",
                           {bus.empty, bus.full, bus.overflow, bus.underflow});
    end
    @(negedge clk);
    rst = 1'b1;
    cmd(1'b1, 1'b0, 8'haa, 1'b0);
    checks++; if (bus.tos !== 8'haa || bus.count !== 3'd1) begin
      failures++; $display("FAIL post_reset_push tos=%h count=%0d exp=aa/1", bus.tos, bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_overflow();
    test_binary_op();
    test_underflow();
    test_replace();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
